int_mem_banks: RTL

INT_MEM_BANKS -- requirements
Module: int_mem_banks

---
 rtl/int_mem_banks_if.sv | 30 +++
 rtl/int_mem_banks.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/int_mem_banks_if.sv
// Bus interface for int_mem_banks: the load stream and the per-bank read ports.
// The master side drives load and read requests; the slave side is the memory.
interface int_mem_banks_if #(
  parameter int NUM_BANKS  = 2,
  parameter int DATA_WIDTH = 5,
  parameter int IN_WIDTH   = 8,
  parameter int ADDR_WIDTH = 8
) ();

  logic                  load_start;
  logic                  in_valid;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_ready;
  logic                  load_done;
  logic                  rd_en    [0:NUM_BANKS-1];
  logic [ADDR_WIDTH-1:0] rd_addr  [0:NUM_BANKS-1];
  logic [DATA_WIDTH-1:0] rd_data  [0:NUM_BANKS-1];
  logic                  rd_valid [0:NUM_BANKS-1];

  modport master (
    output load_start, in_valid, in_data, rd_en, rd_addr,
    input  in_ready, load_done, rd_data, rd_valid
  );

  modport slave (
    input  load_start, in_valid, in_data, rd_en, rd_addr,
    output in_ready, load_done, rd_data, rd_valid
  );

endinterface

// File: rtl/int_mem_banks.sv
// Intrinsic message memory: NUM_BANKS single-port banks filled round-robin from
// a serial LLR stream, then read concurrently with one cycle of latency.
// Optional macro INT_MEM_SAT_EN: clip incoming LLRs to the DATA_WIDTH signed
// range instead of keeping only their low bits.
module int_mem_banks #(
  parameter int NUM_BANKS  = 2,
  parameter int DATA_WIDTH = 5,
  parameter int IN_WIDTH   = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  int_mem_banks_if.slave bus
);

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int TOTAL      = NUM_BANKS * RAM_DEPTH;
  localparam int CNT_WIDTH  = $clog2(TOTAL) + 1;
  localparam int BANK_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t                state_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic [BANK_WIDTH-1:0] bank_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic                  in_ready_reg;
  logic                  load_done_reg;

  logic                  accept;
  logic                  last_word;
  logic                  read_ok;
  logic [DATA_WIDTH-1:0] wr_data;

  // in_ready_reg is high exactly in LOAD, so it doubles as the load-state flag
  assign accept    = in_ready_reg && bus.in_valid;
  assign last_word = (cnt_reg == CNT_WIDTH'(TOTAL - 1));
  assign read_ok   = (state_reg == READY);

  assign bus.in_ready  = in_ready_reg;
  assign bus.load_done = load_done_reg;

`ifdef INT_MEM_SAT_EN
  localparam int SAT_MAX = (1 << (DATA_WIDTH - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DATA_WIDTH - 1));

  logic signed [IN_WIDTH-1:0] in_s;
  assign in_s = $signed(bus.in_data);

  // Clip the incoming LLR into the signed DATA_WIDTH range
  always_comb begin
    wr_data = in_s[DATA_WIDTH-1:0];
    if (in_s > $signed(IN_WIDTH'(SAT_MAX))) begin
      wr_data = DATA_WIDTH'(SAT_MAX);
    end else if (in_s < $signed(IN_WIDTH'(SAT_MIN))) begin
      wr_data = DATA_WIDTH'(SAT_MIN);
    end
  end
`else
  // Keep only the low bits of the LLR; out-of-range values wrap
  assign wr_data = bus.in_data[DATA_WIDTH-1:0];
`endif

  // Load controller: state, word counter, round-robin bank/address pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bank_reg      <= '0;
      waddr_reg     <= '0;
      in_ready_reg  <= 1'b0;
      load_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, READY: begin
          if (bus.load_start) begin
            state_reg     <= LOAD;
            cnt_reg       <= '0;
            bank_reg      <= '0;
            waddr_reg     <= '0;
            in_ready_reg  <= 1'b1;
            load_done_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            // bank index is word mod NUM_BANKS, address is word div NUM_BANKS
            if (bank_reg == BANK_WIDTH'(NUM_BANKS - 1)) begin
              bank_reg  <= '0;
              waddr_reg <= waddr_reg + ADDR_WIDTH'(1);
            end else begin
              bank_reg <= bank_reg + BANK_WIDTH'(1);
            end
            if (last_word) begin
              state_reg     <= READY;
              in_ready_reg  <= 1'b0;
              load_done_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b0;
          load_done_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];
      logic [DATA_WIDTH-1:0] rd_data_reg;
      logic                  rd_valid_reg;
      logic                  wr_sel;
      logic                  rd_sel;

      assign wr_sel = accept && (bank_reg == BANK_WIDTH'(gi));
      assign rd_sel = read_ok && bus.rd_en[gi];

      // Write port: memory contents are deliberately never reset
      always_ff @(posedge clk) begin
        if (wr_sel) begin
          mem[waddr_reg] <= wr_data;
        end
      end

      // Registered read port; data holds when no read is issued
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_sel;
          if (rd_sel) begin
            rd_data_reg <= mem[bus.rd_addr[gi]];
          end
        end
      end

      assign bus.rd_data[gi]  = rd_data_reg;
      assign bus.rd_valid[gi] = rd_valid_reg;
    end
  endgenerate

endmodule
